// File: rtl/seg_scan_driver_if.sv
// Pin-level bundle between the digit encoders / board pins and seg_scan_driver.
// All inputs are level signals sampled every clock; there is no valid/ready handshake.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 6,
   parameter int AN_WIDTH   = 8,
   parameter int DUTY_W     = 4
);
   logic [7*NUM_DIGITS-1:0] seg_bus;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic [DUTY_W-1:0]       brightness;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [6:0]              seg;
   logic                    dp;
   logic [AN_WIDTH-1:0]     an;
   logic                    frame_tick;

   modport master (
      output seg_bus, dp_in, digit_en, brightness, blink_mask,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  seg_bus, dp_in, digit_en, brightness, blink_mask,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with dead time, PWM dimming and frame strobe.
// Optional blinking of masked digits is compiled in when SEGDISP_BLINK_EN is defined.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 6,
   parameter int AN_WIDTH     = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int DEAD_CYC     = 2,
   parameter int DUTY_W       = 4,
   parameter int BLINK_FRAMES = 250
) (
   input logic               clk,
   input logic               rst,
   seg_scan_driver_if.slave  bus
);

   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [PRE_W-1:0] DEAD_LIM = PRE_W'(DEAD_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]  pre;
   logic [IDX_W-1:0]  digit_idx;
   logic [DUTY_W-1:0] pwm;
   logic [DUTY_W-1:0] bri_q;

   logic slot_tick;
   logic frame_wrap;

   assign slot_tick  = (pre == PRE_LAST);
   assign frame_wrap = slot_tick && (digit_idx == IDX_LAST);

   // Scan timebase: prescaler, digit pointer, PWM ramp and slot-aligned brightness.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre       <= '0;
         digit_idx <= '0;
         pwm       <= '0;
         bri_q     <= '1;
      end else begin
         pwm <= pwm + 1'b1;
         if (slot_tick) begin
            pre   <= '0;
            bri_q <= bus.brightness;
            if (frame_wrap) digit_idx <= '0;
            else            digit_idx <= digit_idx + 1'b1;
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end

   logic blank_cur;

`ifdef SEGDISP_BLINK_EN
   localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

   logic [BCNT_W-1:0] blink_cnt;
   logic              blink_phase;

   // Phase flips on the same edge the scan wraps, so a whole frame shares one phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_wrap) begin
         if (blink_cnt == BCNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      blank_cur = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) blank_cur = blink_phase & bus.blink_mask[i];
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^bus.blink_mask;
   assign blank_cur    = 1'b0;
`endif

   logic [6:0] seg_sel;
   logic       dp_sel;
   logic       en_sel;

   always_comb begin
      seg_sel = 7'h7F;
      dp_sel  = 1'b0;
      en_sel  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            seg_sel = bus.seg_bus[7*i +: 7];
            dp_sel  = bus.dp_in[i];
            en_sel  = bus.digit_en[i];
         end
      end
   end

   logic lit;
   assign lit = (pre >= DEAD_LIM) && en_sel && (pwm <= bri_q) && !blank_cur;

   logic [AN_WIDTH-1:0] an_next;
   logic [6:0]          seg_next;
   logic                dp_next;

   // Anodes above NUM_DIGITS are never selected and stay off.
   always_comb begin
      an_next = '1;
      for (int i = 0; i < AN_WIDTH; i++) begin
         if (i < NUM_DIGITS) an_next[i] = !(lit && (digit_idx == IDX_W'(i)));
      end
      seg_next = lit ? seg_sel : 7'h7F;
      dp_next  = lit ? ~dp_sel : 1'b1;
   end

   logic [6:0]          seg_q;
   logic                dp_q;
   logic [AN_WIDTH-1:0] an_q;
   logic                ft_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         an_q  <= '1;
         ft_q  <= 1'b0;
      end else begin
         seg_q <= seg_next;
         dp_q  <= dp_next;
         an_q  <= an_next;
         ft_q  <= frame_wrap;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random inputs,
// compared each cycle against an arithmetic model of the scan timing.
module tb_seg_scan_driver;

   localparam int ND = 3;
   localparam int AW = 4;
   localparam int RD = 8;
   localparam int DC = 1;
   localparam int DW = 2;
   localparam int BF = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   seg_scan_driver_if #(.NUM_DIGITS(ND), .AN_WIDTH(AW), .DUTY_W(DW)) bus ();

   seg_scan_driver #(
      .NUM_DIGITS(ND), .AN_WIDTH(AW), .REFRESH_DIV(RD),
      .DEAD_CYC(DC), .DUTY_W(DW), .BLINK_FRAMES(BF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: k = clock edges since reset release, bri_m = brightness in force.
   int          k = 0;
   logic [DW-1:0] bri_m = '1;
   logic [6:0]    exp_seg;
   logic          exp_dp;
   logic [AW-1:0] exp_an;
   logic          exp_ft;
   int            ft_seen = 0;
   int            lit_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step();
      int pre, d, pwm, f;
      bit blank, lit;
      logic [7*ND-1:0] sb;
      pre   = k % RD;
      d     = (k / RD) % ND;
      pwm   = k % (1 << DW);
      f     = k / (RD * ND);
      blank = 1'b0;
`ifdef SEGDISP_BLINK_EN
      blank = (((f / BF) % 2) == 1) && bus.blink_mask[d];
`endif
      if (f < 0) blank = 1'b0;
      sb  = bus.seg_bus;
      lit = (pre >= DC) && bus.digit_en[d] && (pwm <= int'(bri_m)) && !blank;
      if (rst) begin
         exp_seg = 7'h7F;
         exp_dp  = 1'b1;
         exp_an  = '1;
         exp_ft  = 1'b0;
         k       = 0;
         bri_m   = '1;
      end else begin
         exp_an  = '1;
         if (lit) exp_an[d] = 1'b0;
         exp_seg = lit ? sb[7*d +: 7] : 7'h7F;
         exp_dp  = lit ? ~bus.dp_in[d] : 1'b1;
         exp_ft  = ((k % (RD * ND)) == (RD * ND - 1));
         if (pre == RD - 1) bri_m = bus.brightness;
         k++;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("seg", 32'(bus.seg), 32'(exp_seg));
      chk("dp", 32'(bus.dp), 32'(exp_dp));
      chk("an", 32'(bus.an), 32'(exp_an));
      chk("frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
      if (bus.frame_tick === 1'b1) ft_seen++;
      if (bus.an !== '1) lit_cnt++;
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, "_seg"}, 32'(bus.seg), 32'h7F);
      chk({tag, "_dp"}, 32'(bus.dp), 32'h1);
      chk({tag, "_an"}, 32'(bus.an), 32'(AW'('1)));
      chk({tag, "_ft"}, 32'(bus.frame_tick), 32'h0);
   endtask

   initial begin
      bus.seg_bus    = {7'h30, 7'h24, 7'h40};
      bus.dp_in      = '0;
      bus.digit_en   = '1;
      bus.brightness = 2'd3;
      bus.blink_mask = '0;

      // Power-on reset.
      #2 rst = 1'b1;
      #1 chk_dark("reset");
      repeat (2) tick();
      rst = 1'b0;

      // Full brightness, all digits: 7 of 8 cycles lit per slot, one strobe per frame.
      ft_seen = 0;
      lit_cnt = 0;
      repeat (2 * RD * ND) tick();
      chk("frame_tick_count", 32'(ft_seen), 32'd2);
      chk("lit_count", 32'(lit_cnt), 32'd42);

      // Middle digit blanked.
      bus.digit_en = 3'b101;
      repeat (RD * ND) tick();
      bus.digit_en = '1;

      // Brightness change mid-slot only takes effect from the next slot.
      while (k % RD != 3) tick();
      bus.brightness = 2'd1;
      repeat (RD * ND) tick();

      // Brightness change on the slot boundary edge itself is captured.
      while (k % RD != RD - 1) tick();
      bus.brightness = 2'd2;
      repeat (2 * RD) tick();
      bus.brightness = 2'd3;

      // Decimal point on digit 1 only.
      bus.dp_in = 3'b010;
      repeat (RD * ND) tick();

      // Asynchronous reset in the middle of digit 2's slot.
      while (k % (RD * ND) != 2 * RD + 5) tick();
      rst = 1'b1;
      #1 chk_dark("async_reset");
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("post_reset_dead_an", 32'(bus.an), 32'(AW'('1)));
      tick();
      chk("post_reset_first_lit_an", 32'(bus.an), 32'(4'b1110));

      // Random inputs.
      for (int n = 0; n < 480; n++) begin
         bus.seg_bus    = (7 * ND)'({$urandom, $urandom});
         bus.dp_in      = ND'($urandom);
         bus.digit_en   = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '1;
         bus.blink_mask = ND'($urandom);
         if ($urandom_range(0, 7) == 0) bus.brightness = DW'($urandom_range(0, 3));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
